// File: rtl/ipm2t_hssthp_apb_cfg_pkg.sv
// ipm2t_hssthp_apb_cfg_pkg: shared encodings for the HSSTHP APB config master
package ipm2t_hssthp_apb_cfg_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam logic [1:0] ERR_OK = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_BADADDR = 2'd2;
  localparam logic [3:0] SEL_CH0 = 4'd0;
  localparam logic [3:0] SEL_CH1 = 4'd1;
  localparam logic [3:0] SEL_CH2 = 4'd2;
  localparam logic [3:0] SEL_CH3 = 4'd3;
  localparam logic [3:0] SEL_HPLL = 4'd4;
  function automatic logic [7:0] rmw_merge(input logic [7:0] rd, input logic [7:0] wd, input logic [7:0] m);
    return (rd & ~m) | (wd & m);
  endfunction
endpackage

// File: rtl/ipm2t_hssthp_apb_cfg_master.sv
// ipm2t_hssthp_apb_cfg_master: APB initiator for write/read/RMW config accesses with timeout and address check
module ipm2t_hssthp_apb_cfg_master
  import ipm2t_hssthp_apb_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_SEL = 4
) (
  input  logic        p_cfg_clk,
  input  logic        p_cfg_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_rmw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic [7:0]  cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic        p_cfg_psel,
  output logic        p_cfg_enable,
  output logic        p_cfg_write,
  output logic [15:0] p_cfg_addr,
  output logic [7:0]  p_cfg_wdata,
  input  logic        p_cfg_ready,
  input  logic [7:0]  p_cfg_rdata
);
  logic [1:0] state, state_nx;
  logic rmw_q, wr_q, phase_q;
  logic [15:0] addr_q, cnt_q;
  logic [7:0] wdata_q, mask_q, rdata_q;
  logic [1:0] err_q;
  logic bad_addr, apb_wr, hit;
  assign bad_addr = cmd_addr[15:12] > 4'(MAX_SEL);
  assign apb_wr = rmw_q ? phase_q : wr_q;
  assign hit = cnt_q == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge p_cfg_clk or negedge p_cfg_rst_n)
    if (!p_cfg_rst_n) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = cmd_valid ? (bad_addr ? ST_RESP : ST_SETUP) : ST_IDLE;
      ST_SETUP: state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = p_cfg_ready ? ((rmw_q && !phase_q) ? ST_SETUP : ST_RESP) : (hit ? ST_RESP : ST_ACCESS);
      default: state_nx = rsp_ready ? ST_IDLE : ST_RESP;
    endcase
  end
  always_comb begin
    cmd_ready = state == ST_IDLE;
    busy = state != ST_IDLE;
    p_cfg_psel = state == ST_SETUP || state == ST_ACCESS;
    p_cfg_enable = state == ST_ACCESS;
    p_cfg_write = p_cfg_psel && apb_wr;
    p_cfg_addr = p_cfg_psel ? addr_q : '0;
    p_cfg_wdata = p_cfg_psel ? wdata_q : '0;
    rsp_valid = state == ST_RESP;
    rsp_rdata = rsp_valid ? rdata_q : '0;
    rsp_err = rsp_valid ? err_q : ERR_OK;
  end
  always_ff @(posedge p_cfg_clk or negedge p_cfg_rst_n)
    if (!p_cfg_rst_n) begin
      rmw_q <= 1'b0;
      wr_q <= 1'b0;
      phase_q <= 1'b0;
      addr_q <= '0;
      cnt_q <= '0;
      wdata_q <= '0;
      mask_q <= '0;
      rdata_q <= '0;
      err_q <= ERR_OK;
    end else begin
      if (state == ST_IDLE && cmd_valid) begin
        addr_q <= cmd_addr;
        wr_q <= cmd_write;
        rmw_q <= cmd_rmw;
        wdata_q <= cmd_wdata;
        mask_q <= cmd_mask;
        phase_q <= 1'b0;
        rdata_q <= '0;
        cnt_q <= '0;
        err_q <= bad_addr ? ERR_BADADDR : ERR_OK;
      end
      if (state == ST_SETUP) cnt_q <= '0;
      if (state == ST_ACCESS) begin
        cnt_q <= cnt_q + 16'd1;
        if (p_cfg_ready) begin
          if (!apb_wr) rdata_q <= p_cfg_rdata;
          if (rmw_q && !phase_q) begin
            phase_q <= 1'b1;
            wdata_q <= rmw_merge(p_cfg_rdata, wdata_q, mask_q);
          end
        end else if (hit) begin
          err_q <= ERR_TIMEOUT;
          rdata_q <= '0;
        end
      end
    end
endmodule

// File: tb/tb_ipm2t_hssthp_apb_cfg_master.sv
// tb_ipm2t_hssthp_apb_cfg_master: directed self-checking bench with a simple APB slave
module tb_ipm2t_hssthp_apb_cfg_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, cmd_rmw = 1'b0, rsp_ready = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0, cmd_mask = '0;
  logic cmd_ready, rsp_valid, busy, p_cfg_psel, p_cfg_enable, p_cfg_write, p_cfg_ready;
  logic [7:0] rsp_rdata, p_cfg_wdata, p_cfg_rdata;
  logic [1:0] rsp_err;
  logic [15:0] p_cfg_addr;
  int checks = 0, errors = 0;
  int wait_n = 0;
  logic stuck = 1'b0, load = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] mem = '0;
  int acnt = 0, psel_cnt = 0, en_cnt = 0, wr_cnt = 0;
  int lat, e0, p0, w0;
  ipm2t_hssthp_apb_cfg_master #(.TIMEOUT_CYC(8), .MAX_SEL(4)) dut (
    .p_cfg_clk(clk), .p_cfg_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_rmw(cmd_rmw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .p_cfg_psel(p_cfg_psel), .p_cfg_enable(p_cfg_enable), .p_cfg_write(p_cfg_write),
    .p_cfg_addr(p_cfg_addr), .p_cfg_wdata(p_cfg_wdata), .p_cfg_ready(p_cfg_ready), .p_cfg_rdata(p_cfg_rdata)
  );
  always #5 clk = ~clk;
  assign p_cfg_ready = p_cfg_psel && p_cfg_enable && !stuck && acnt >= wait_n;
  assign p_cfg_rdata = mem;
  always_ff @(posedge clk) begin
    acnt <= (p_cfg_psel && p_cfg_enable && !p_cfg_ready) ? acnt + 1 : 0;
    psel_cnt <= psel_cnt + int'(p_cfg_psel);
    en_cnt <= en_cnt + int'(p_cfg_enable);
    wr_cnt <= wr_cnt + int'(p_cfg_psel && p_cfg_enable && p_cfg_ready && p_cfg_write);
    if (load) mem <= load_val;
    else if (p_cfg_psel && p_cfg_enable && p_cfg_ready && p_cfg_write) mem <= p_cfg_wdata;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_slave(input int w, input logic s, input logic [7:0] v);
    wait_n = w;
    stuck = s;
    load_val = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask
  task automatic run_cmd(input logic wr, input logic rmw, input logic [15:0] a, input logic [7:0] d, input logic [7:0] m, output int l);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_rmw = rmw;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_mask = m;
    step();
    cmd_valid = 1'b0;
    l = 1;
    while (!rsp_valid && l < 50) begin
      step();
      l++;
    end
  endtask
  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset();
    step();
    step();
    checks++;
    if ({cmd_ready, rsp_valid, busy, p_cfg_psel, p_cfg_enable, p_cfg_write, p_cfg_addr, p_cfg_wdata, rsp_rdata, rsp_err} !== {1'b1, 5'b0, 16'h0, 8'h0, 8'h0, 2'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b val=%b busy=%b psel=%b en=%b addr=%h", cmd_ready, rsp_valid, busy, p_cfg_psel, p_cfg_enable, p_cfg_addr);
    end
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_write();
    set_slave(0, 1'b0, 8'h00);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_rmw = 1'b0;
    cmd_addr = 16'h4012;
    cmd_wdata = 8'hA5;
    cmd_mask = 8'h00;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL write_cmd_ready: got %b exp 1", cmd_ready); end
    step();
    checks++;
    if ({p_cfg_psel, p_cfg_enable, p_cfg_write, p_cfg_addr, p_cfg_wdata, cmd_ready, busy} !== {3'b101, 16'h4012, 8'hA5, 2'b01}) begin
      errors++;
      $display("FAIL write_setup: got psel=%b en=%b wr=%b addr=%h wd=%h rdy=%b busy=%b", p_cfg_psel, p_cfg_enable, p_cfg_write, p_cfg_addr, p_cfg_wdata, cmd_ready, busy);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({p_cfg_psel, p_cfg_enable, p_cfg_write, p_cfg_addr, p_cfg_wdata, rsp_valid} !== {3'b111, 16'h4012, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL write_access: got psel=%b en=%b wr=%b addr=%h wd=%h val=%b", p_cfg_psel, p_cfg_enable, p_cfg_write, p_cfg_addr, p_cfg_wdata, rsp_valid);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, p_cfg_psel, p_cfg_enable, cmd_ready} !== {1'b1, 2'd0, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL write_resp: got val=%b err=%0d rd=%h psel=%b en=%b rdy=%b", rsp_valid, rsp_err, rsp_rdata, p_cfg_psel, p_cfg_enable, cmd_ready);
    end
    checks++;
    if (mem !== 8'hA5) begin errors++; $display("FAIL write_mem: got %h exp a5", mem); end
    step();
    step();
    checks++;
    if ({rsp_valid, rsp_err, cmd_ready, busy} !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL write_resp_hold: got val=%b err=%0d rdy=%b busy=%b", rsp_valid, rsp_err, cmd_ready, busy);
    end
    consume();
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL write_release: got val=%b rdy=%b busy=%b exp 0 1 0", rsp_valid, cmd_ready, busy);
    end
  endtask
  task automatic test_read_wait();
    set_slave(3, 1'b0, 8'h3C);
    e0 = en_cnt;
    run_cmd(1'b0, 1'b0, 16'h1034, 8'h00, 8'h00, lat);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL read_latency: got %0d exp 6", lat); end
    checks++;
    if (en_cnt - e0 !== 4) begin errors++; $display("FAIL read_enable_cycles: got %0d exp 4", en_cnt - e0); end
    checks++;
    if ({rsp_rdata, rsp_err} !== {8'h3C, 2'd0}) begin errors++; $display("FAIL read_data: got rd=%h err=%0d exp 3c 0", rsp_rdata, rsp_err); end
    consume();
  endtask
  task automatic test_rmw();
    set_slave(0, 1'b0, 8'h0F);
    w0 = wr_cnt;
    p0 = psel_cnt;
    run_cmd(1'b0, 1'b1, 16'h2100, 8'hF0, 8'h30, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL rmw_latency: got %0d exp 5", lat); end
    checks++;
    if ({rsp_rdata, rsp_err} !== {8'h0F, 2'd0}) begin errors++; $display("FAIL rmw_resp: got rd=%h err=%0d exp 0f 0", rsp_rdata, rsp_err); end
    checks++;
    if (mem !== 8'h3F) begin errors++; $display("FAIL rmw_merged: got %h exp 3f", mem); end
    checks++;
    if ({wr_cnt - w0, psel_cnt - p0} !== {32'd1, 32'd4}) begin
      errors++;
      $display("FAIL rmw_transfers: got writes=%0d psel=%0d exp 1 4", wr_cnt - w0, psel_cnt - p0);
    end
    consume();
  endtask
  task automatic test_bad_addr();
    p0 = psel_cnt;
    run_cmd(1'b1, 1'b0, 16'h7000, 8'h55, 8'h00, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL badaddr_latency: got %0d exp 1", lat); end
    checks++;
    if ({rsp_err, rsp_rdata} !== {2'd2, 8'h00}) begin errors++; $display("FAIL badaddr_resp: got err=%0d rd=%h exp 2 00", rsp_err, rsp_rdata); end
    consume();
    checks++;
    if (psel_cnt - p0 !== 0) begin errors++; $display("FAIL badaddr_psel: got %0d exp 0", psel_cnt - p0); end
  endtask
  task automatic test_timeout();
    set_slave(0, 1'b1, 8'h99);
    e0 = en_cnt;
    run_cmd(1'b0, 1'b0, 16'h0123, 8'h00, 8'h00, lat);
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL timeout_latency: got %0d exp 10", lat); end
    checks++;
    if (en_cnt - e0 !== 8) begin errors++; $display("FAIL timeout_enable_cycles: got %0d exp 8", en_cnt - e0); end
    checks++;
    if ({rsp_err, rsp_rdata} !== {2'd1, 8'h00}) begin errors++; $display("FAIL timeout_resp: got err=%0d rd=%h exp 1 00", rsp_err, rsp_rdata); end
    consume();
    p0 = psel_cnt;
    w0 = wr_cnt;
    run_cmd(1'b0, 1'b1, 16'h3000, 8'hFF, 8'hFF, lat);
    checks++;
    if ({lat, rsp_err} !== {32'd10, 2'd1}) begin errors++; $display("FAIL rmw_timeout_resp: got lat=%0d err=%0d exp 10 1", lat, rsp_err); end
    consume();
    checks++;
    if ({psel_cnt - p0, wr_cnt - w0} !== {32'd9, 32'd0}) begin
      errors++;
      $display("FAIL rmw_timeout_no_write: got psel=%0d writes=%0d exp 9 0", psel_cnt - p0, wr_cnt - w0);
    end
  endtask
  task automatic test_timeout_edge();
    set_slave(7, 1'b0, 8'h5A);
    run_cmd(1'b0, 1'b0, 16'h0200, 8'h00, 8'h00, lat);
    checks++;
    if ({lat, rsp_err, rsp_rdata} !== {32'd10, 2'd0, 8'h5A}) begin
      errors++;
      $display("FAIL timeout_edge: got lat=%0d err=%0d rd=%h exp 10 0 5a", lat, rsp_err, rsp_rdata);
    end
    consume();
  endtask
  task automatic test_reset_mid();
    int bad;
    set_slave(3, 1'b0, 8'h11);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_rmw = 1'b1;
    cmd_addr = 16'h2000;
    cmd_wdata = 8'h00;
    cmd_mask = 8'hFF;
    step();
    cmd_valid = 1'b0;
    step();
    checks++;
    if ({p_cfg_psel, p_cfg_enable} !== 2'b11) begin errors++; $display("FAIL midrst_access: got psel=%b en=%b exp 1 1", p_cfg_psel, p_cfg_enable); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({p_cfg_psel, p_cfg_enable, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL midrst_async: got psel=%b en=%b val=%b busy=%b rdy=%b", p_cfg_psel, p_cfg_enable, rsp_valid, busy, cmd_ready);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      bad += int'(rsp_valid);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      bad += int'(rsp_valid);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midrst_no_resp: got %0d valid cycles exp 0", bad); end
    set_slave(0, 1'b0, 8'h00);
    run_cmd(1'b1, 1'b0, 16'h4001, 8'h77, 8'h00, lat);
    checks++;
    if ({lat, rsp_err, mem} !== {32'd3, 2'd0, 8'h77}) begin
      errors++;
      $display("FAIL midrst_recover: got lat=%0d err=%0d mem=%h exp 3 0 77", lat, rsp_err, mem);
    end
    consume();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_rmw();
    test_bad_addr();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ipm2t_hssthp_apb_cfg_master.md
Name: ipm2t_hssthp_apb_cfg_master

Overview:
APB initiator that drives the fabric-side p_cfg_* port of the HSSTHP APB bridge. It converts single-beat commands from user or DRP-sequencer logic into APB setup/access transfers: write, read, or masked read-modify-write.
Adds a per-access timeout and rejects addresses outside the decoded range (channels 0-3, HPLL), so a stalled or unmapped slave cannot hang the config path. Sits between the transceiver init/reconfig controller and the bridge, in the p_cfg_clk domain.

Parameters:
TIMEOUT_CYC, 255, max ACCESS-phase cycles waiting for p_cfg_ready before abort; legal range 1..65535.
MAX_SEL, 4, highest legal p_cfg_addr[15:12] value; above it is rejected.

Ports:
p_cfg_clk  in  1  config clock; all logic on rising edge
p_cfg_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read; ignored when cmd_rmw=1
cmd_rmw  in  1  1=masked read-modify-write
cmd_addr  in  16  [15:12] target select, [11:0] register
cmd_wdata  in  8  write data
cmd_mask  in  8  RMW bit mask, 1=take cmd_wdata bit
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
rsp_rdata  out  8  read data; for RMW, original read value
rsp_err  out  2  0=OK, 1=timeout, 2=bad address
busy  out  1  high whenever state is not IDLE
p_cfg_psel  out  1  APB select
p_cfg_enable  out  1  APB enable
p_cfg_write  out  1  APB direction
p_cfg_addr  out  16  APB address
p_cfg_wdata  out  8  APB write data
p_cfg_ready  in  1  APB ready from bridge
p_cfg_rdata  in  8  APB read data from bridge

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State IDLE.
  - All outputs 0 except cmd_ready=1.
  - Internal command registers and timeout counter cleared.
- Reset mid-transfer: psel/enable drop immediately and no response is issued; the issuer must resubmit.
- States: IDLE, SETUP, ACCESS, RESP. An internal phase bit marks RMW read vs RMW write.
- IDLE:
  - cmd_ready=1; all other outputs 0.
  - On handshake, register cmd_* fields.
  - If cmd_addr[15:12] > MAX_SEL: go to RESP with rsp_err=2 and rsp_rdata=0; no APB activity.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, enable=0.
  - addr, write, wdata driven from registers; write=0 for the RMW read phase.
  - p_cfg_ready is ignored. Next state: ACCESS.
- ACCESS:
  - psel=1, enable=1; timeout counter increments each cycle.
  - On a cycle with p_cfg_ready=1: capture p_cfg_rdata (reads only). Next cycle psel=0, enable=0.
    - Plain read/write: go to RESP with err=0.
    - RMW read phase: merged = (rdata & ~mask) | (wdata & mask). Go to SETUP for the write phase with write=1, wdata=merged.
    - RMW write phase: go to RESP with rsp_rdata = original read value.
  - If the counter reaches TIMEOUT_CYC with ready still 0: abort. Go to RESP with err=1 and rsp_rdata=0; an RMW write phase is never issued after a read timeout.
  - Counter clears on every SETUP entry.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On handshake, go to IDLE; cmd_ready returns 1 on the following cycle. No same-cycle command acceptance in RESP.
- APB addr/write/wdata are stable from SETUP through the last ACCESS cycle. psel/enable never both low between SETUP and ACCESS within one transfer.
- Latency (cmd handshake edge = cycle 0, zero-wait slave): SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3. RMW: rsp_valid in cycle 5.
- Write ack: rsp_rdata=0 for plain writes.
- Simultaneous cases:
  - p_cfg_ready=1 on the same cycle the counter hits TIMEOUT_CYC counts as success.
  - cmd_valid while busy is ignored (cmd_ready=0).

Decomposition:
- Package ipm2t_hssthp_apb_cfg_pkg holds:
  - state encoding localparams
  - rsp_err codes (ERR_OK=0, ERR_TIMEOUT=1, ERR_BADADDR=2)
  - select codes (SEL_CH0..SEL_CH3=0..3, SEL_HPLL=4)
- No sub-module; FSM, timeout counter and merge logic stay in one file.

Test Plan:
- Write 0x4012=0xA5, zero-wait slave -> psel high cycles 1-2, enable cycle 2, write=1, rsp_valid cycle 3, err=0.
- Read 0x1034, slave ready after 3 wait cycles with rdata=0x3C -> enable held 4 cycles, rsp_rdata=0x3C, err=0.
- RMW 0x2100, wdata=0xF0, mask=0x30, slave holds 0x0F -> second transfer writes 0x3F, rsp_rdata=0x0F.
- Command to 0x7000 -> rsp_err=2 at cycle 1, psel never asserts.
- Read with TIMEOUT_CYC=8, ready stuck 0 -> enable high exactly 8 cycles then drops, rsp_err=1; RMW variant shows no write phase.
- Reset asserted during ACCESS of an RMW, rsp_ready held low across RESP -> outputs clear asynchronously, no rsp_valid; after release, first command completes normally.
